// File: rtl/dso_trig_ctrl_if.sv
// Capture-buffer write port and frame handshake between the trigger
// sequencer (master) and the ring buffer / display reader (slave).
interface dso_trig_ctrl_if #(
   parameter int AW = 10
) ();

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_valid;
   logic [AW-1:0] trig_addr;
   logic          forced;
   logic          frame_ack;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output frame_valid,
      output trig_addr,
      output forced,
      input  frame_ack
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  frame_valid,
      input  trig_addr,
      input  forced,
      output frame_ack
   );

endinterface

// File: rtl/dso_trig_ctrl.sv
// Oscilloscope capture sequencer: decimates ADC samples into a circular
// buffer, waits for a level/edge (or auto-timeout) trigger, frames a fixed
// pre/post window and holds the frame until the display releases it.
module dso_trig_ctrl #(
   parameter int AW      = 10,
   parameter int PRE     = 256,
   parameter int AUTO_TO = 4096
) (
   input  logic         ad_clk,
   input  logic         sys_rst_n,
   input  logic [7:0]   ad_data,
   input  logic [15:0]  deci,
   input  logic [7:0]   trig_level,
   input  logic         trig_edge,
   input  logic         trig_auto,
   input  logic         run,
   output logic         busy,
   dso_trig_ctrl_if.master bus
);

   localparam int            N         = 1 << AW;
   localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
   localparam logic [AW-1:0] POST_LAST = AW'(N - PRE - 2);
   localparam logic [31:0]   AUTO_LIM  = 32'(AUTO_TO);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ARM,
      ST_POST,
      ST_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] ptr;
   logic [15:0]   dcnt;
   logic [7:0]    prev;
   logic [AW-1:0] pcnt;
   logic [31:0]   tcnt;
   logic [AW-1:0] post_cnt;

   logic [15:0]   deci_l;
   logic [7:0]    level_l;
   logic          edge_l;
   logic          auto_l;

   logic          strobe;
   logic          edge_hit;
   logic [31:0]   tcnt_inc;
   logic          timed_out;

   // Strobe, edge detection and auto-timeout are decided combinationally on the strobe cycle
   always_comb begin
      strobe    = 1'b0;
      edge_hit  = 1'b0;
      tcnt_inc  = tcnt;
      timed_out = 1'b0;
      strobe = (dcnt == deci_l);
      if (edge_l) begin
         edge_hit = (prev > level_l) && (ad_data <= level_l);
      end else begin
         edge_hit = (prev < level_l) && (ad_data >= level_l);
      end
      if (tcnt != 32'hFFFF_FFFF) begin
         tcnt_inc = tcnt + 32'd1;
      end
      timed_out = auto_l && (tcnt_inc >= AUTO_LIM);
   end

   // Capture state machine with registered write port, frame outputs and busy flag
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         dcnt            <= '0;
         prev            <= '0;
         pcnt            <= '0;
         tcnt            <= '0;
         post_cnt        <= '0;
         deci_l          <= '0;
         level_l         <= '0;
         edge_l          <= 1'b0;
         auto_l          <= 1'b0;
         busy            <= 1'b0;
         bus.wr_en       <= 1'b0;
         bus.wr_addr     <= '0;
         bus.wr_data     <= '0;
         bus.frame_valid <= 1'b0;
         bus.trig_addr   <= '0;
         bus.forced      <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run && !bus.frame_valid) begin
                  state   <= ST_PRE;
                  busy    <= 1'b1;
                  deci_l  <= deci;
                  level_l <= trig_level;
                  edge_l  <= trig_edge;
                  auto_l  <= trig_auto;
                  dcnt    <= '0;
                  pcnt    <= '0;
                  tcnt    <= '0;
               end
            end

            ST_PRE, ST_ARM, ST_POST: begin
               if (!run) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (strobe) begin
                  dcnt        <= '0;
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= ptr;
                  bus.wr_data <= ad_data;
                  ptr         <= ptr + AW'(1);
                  prev        <= ad_data;
                  if (state == ST_PRE) begin
                     pcnt <= pcnt + AW'(1);
                     if (pcnt == PRE_LAST) begin
                        state <= ST_ARM;
                     end
                  end else if (state == ST_ARM) begin
                     tcnt <= tcnt_inc;
                     if (edge_hit || timed_out) begin
                        bus.trig_addr <= ptr;
                        bus.forced    <= !edge_hit;
                        post_cnt      <= '0;
                        state         <= ST_POST;
                     end
                  end else begin
                     post_cnt <= post_cnt + AW'(1);
                     if (post_cnt == POST_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                     end
                  end
               end else begin
                  dcnt <= dcnt + 16'd1;
               end
            end

            ST_DONE: begin
               if (bus.frame_ack && bus.frame_valid) begin
                  bus.frame_valid <= 1'b0;
                  state           <= ST_IDLE;
               end else begin
                  bus.frame_valid <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dso_trig_ctrl.sv
// Directed self-checking bench for the oscilloscope capture sequencer.
module tb_dso_trig_ctrl;

   logic        ad_clk;
   logic        sys_rst_n;
   logic [7:0]  ad_data;
   logic [15:0] deci;
   logic [7:0]  trig_level;
   logic        trig_edge;
   logic        trig_auto;
   logic        run;
   logic        busy;

   dso_trig_ctrl_if #(.AW(10)) bus ();

   dso_trig_ctrl #(
      .AW(10),
      .PRE(256),
      .AUTO_TO(4096)
   ) dut (
      .ad_clk(ad_clk),
      .sys_rst_n(sys_rst_n),
      .ad_data(ad_data),
      .deci(deci),
      .trig_level(trig_level),
      .trig_edge(trig_edge),
      .trig_auto(trig_auto),
      .run(run),
      .busy(busy),
      .bus(bus)
   );

   logic [7:0] mem [0:1023];
   int errors;
   int checks;
   int wr_cnt;
   int consec;
   int ramp_idx;
   int data_mode;
   logic [7:0] const_val;
   logic fv_seen;
   logic last_we;

   // Free-running sample clock, 10 time-unit period
   initial begin
      ad_clk = 1'b0;
      forever #5 ad_clk = ~ad_clk;
   end

   // One cycle: sample outputs on the falling edge, record writes, drive next sample
   task automatic tick();
      @(negedge ad_clk);
      if (bus.wr_en) begin
         mem[bus.wr_addr] = bus.wr_data;
         wr_cnt++;
      end
      if (bus.frame_valid) fv_seen = 1'b1;
      case (data_mode)
         1:       ad_data = 8'(ramp_idx);
         2:       ad_data = 8'(255 - (ramp_idx >> 2));
         default: ad_data = const_val;
      endcase
      ramp_idx++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [7:0] lvl,
                                input logic e, input logic a, input int mode);
      deci       = d;
      trig_level = lvl;
      trig_edge  = e;
      trig_auto  = a;
      data_mode  = mode;
      ramp_idx   = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic waitFrame(input int bound);
      int n;
      n = 0;
      while (!bus.frame_valid && n < bound) begin
         tick();
         n++;
      end
      checkOutput("frame_valid_timeout", 32'(bus.frame_valid), 32'd1);
   endtask

   // Directed scenario sequence
   initial begin
      errors = 0; checks = 0; wr_cnt = 0; consec = 0;
      ramp_idx = 0; data_mode = 0; const_val = 8'd0; fv_seen = 1'b0; last_we = 1'b0;
      sys_rst_n = 1'b0; ad_data = 8'd0; run = 1'b0; bus.frame_ack = 1'b0;
      deci = 16'd0; trig_level = 8'd0; trig_edge = 1'b0; trig_auto = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;

      $display("[TB] reset values");
      ticks(3);
      checkOutput("rst_wr_en",       32'(bus.wr_en),       32'd0);
      checkOutput("rst_wr_addr",     32'(bus.wr_addr),     32'd0);
      checkOutput("rst_wr_data",     32'(bus.wr_data),     32'd0);
      checkOutput("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
      checkOutput("rst_trig_addr",   32'(bus.trig_addr),   32'd0);
      checkOutput("rst_forced",      32'(bus.forced),      32'd0);
      checkOutput("rst_busy",        32'(busy),            32'd0);
      sys_rst_n = 1'b1;
      tick();

      $display("[TB] rising trigger, deci=0, level=128, ramp from pointer 0");
      applyStimulus(16'd0, 8'd128, 1'b0, 1'b0, 1);
      wr_cnt = 0;
      run = 1'b1;
      tick();
      checkOutput("rise_busy", 32'(busy), 32'd1);
      waitFrame(2000);
      checkOutput("rise_trig_addr", 32'(bus.trig_addr), 32'd384);
      checkOutput("rise_forced",    32'(bus.forced),    32'd0);
      checkOutput("rise_buf_trig",  32'(mem[384]),      32'd128);
      checkOutput("rise_buf_prev",  32'(mem[383]),      32'd127);
      checkOutput("rise_buf_next",  32'(mem[385]),      32'd129);
      checkOutput("rise_wr_pulses", 32'(wr_cnt),        32'd1152);

      $display("[TB] frame held while ack stays low");
      wr_cnt = 0;
      ticks(500);
      checkOutput("hold_wr_pulses",  32'(wr_cnt),           32'd0);
      checkOutput("hold_frame_valid", 32'(bus.frame_valid), 32'd1);
      checkOutput("hold_busy",       32'(busy),             32'd0);

      $display("[TB] ack releases frame, falling trigger with deci=3 starts");
      applyStimulus(16'd3, 8'd100, 1'b1, 1'b0, 2);
      wr_cnt = 0;
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
      checkOutput("ack_frame_valid", 32'(bus.frame_valid), 32'd0);
      checkOutput("ack_busy_t1",     32'(busy),             32'd0);
      tick();
      checkOutput("ack_busy_t2",     32'(busy),             32'd1);
      ticks(18);
      wr_cnt = 0;
      consec = 0;
      last_we = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.wr_en && last_we) consec++;
         last_we = bus.wr_en;
      end
      checkOutput("deci_pulses_in_40", 32'(wr_cnt), 32'd10);
      checkOutput("deci_back_to_back", 32'(consec), 32'd0);
      ticks(1140);
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
      checkOutput("arm_ack_busy",        32'(busy),            32'd1);
      checkOutput("arm_ack_frame_valid", 32'(bus.frame_valid), 32'd0);
      waitFrame(6000);
      checkOutput("fall_trig_addr", 32'(bus.trig_addr), 32'd538);
      checkOutput("fall_forced",    32'(bus.forced),    32'd0);
      checkOutput("fall_buf_trig",  32'(mem[538]),      32'd100);
      checkOutput("fall_buf_prev",  32'(mem[537]),      32'd101);

      $display("[TB] normal mode with flat input never triggers");
      applyStimulus(16'd0, 8'd128, 1'b0, 1'b0, 0);
      const_val = 8'd50;
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
      ticks(9);
      wr_cnt = 0;
      fv_seen = 1'b0;
      ticks(19990);
      checkOutput("noauto_wr_pulses", 32'(wr_cnt),  32'd19990);
      checkOutput("noauto_no_frame",  32'(fv_seen), 32'd0);

      $display("[TB] asynchronous reset while armed");
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("arst_wr_en",     32'(bus.wr_en),     32'd0);
      checkOutput("arst_wr_addr",   32'(bus.wr_addr),   32'd0);
      checkOutput("arst_wr_data",   32'(bus.wr_data),   32'd0);
      checkOutput("arst_trig_addr", 32'(bus.trig_addr), 32'd0);
      checkOutput("arst_busy",      32'(busy),          32'd0);
      run = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      tick();

      $display("[TB] auto trigger on flat input");
      applyStimulus(16'd0, 8'd128, 1'b0, 1'b1, 0);
      wr_cnt = 0;
      run = 1'b1;
      waitFrame(6000);
      checkOutput("auto_forced",    32'(bus.forced),    32'd1);
      checkOutput("auto_trig_addr", 32'(bus.trig_addr), 32'd255);
      checkOutput("auto_wr_pulses", 32'(wr_cnt),        32'd5119);

      $display("[TB] abort during post-trigger phase");
      applyStimulus(16'd0, 8'd128, 1'b0, 1'b0, 1);
      wr_cnt = 0;
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
      fv_seen = 1'b0;
      ticks(601);
      run = 1'b0;
      tick();
      checkOutput("abort_busy",  32'(busy),      32'd0);
      checkOutput("abort_wr_en", 32'(bus.wr_en), 32'd0);
      ticks(50);
      checkOutput("abort_wr_pulses", 32'(wr_cnt),  32'd600);
      checkOutput("abort_no_frame",  32'(fv_seen), 32'd0);

      $display("[TB] restart after abort, auto trigger");
      applyStimulus(16'd0, 8'd128, 1'b0, 1'b1, 0);
      wr_cnt = 0;
      run = 1'b1;
      waitFrame(6000);
      checkOutput("restart_trig_addr", 32'(bus.trig_addr), 32'd854);
      checkOutput("restart_forced",    32'(bus.forced),    32'd1);
      checkOutput("restart_wr_pulses", 32'(wr_cnt),        32'd5119);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
